alu_32_control: RTL and testbench

ALU control decoder for the MIPS single-cycle datapath. It maps the main-control ALUOp and a 6-bit code field onto a 4-bit ALU operation select, ALUCtr. The 6-bit field carries the R-type funct for ALUOp=100 and the instruction opcode for ALUOp=010. ALUCtr is purely combinational, so the ALU operation is valid in the same cycle. A clocked sticky status flag records any illegal decode.

---
 rtl/alu_pkg.sv | 106 ++++++++++
 rtl/alu_32_control.sv | 58 +++++
 tb/tb_alu_32_control.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared encodings for the MIPS single-cycle ALU path.
//   - ALUCtr operation selects, also used by the ALU itself
//   - ALUOp class codes produced by main control
//   - R-type funct codes and I-type opcodes seen by the ALU control decoder
//   - rtype_decode / itype_decode: map a 6-bit code onto {illegal, ALUCtr}
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALU operation selects
    localparam logic [3:0] CTR_AND  = 4'b0000;
    localparam logic [3:0] CTR_OR   = 4'b0001;
    localparam logic [3:0] CTR_ADD  = 4'b0010;
    localparam logic [3:0] CTR_ADDU = 4'b0011;
    localparam logic [3:0] CTR_SUB  = 4'b0110;
    localparam logic [3:0] CTR_SUBU = 4'b0111;
    localparam logic [3:0] CTR_SLT  = 4'b1000;
    localparam logic [3:0] CTR_SLTU = 4'b1001;
    localparam logic [3:0] CTR_SLL  = 4'b1010;
    localparam logic [3:0] CTR_SRL  = 4'b1011;
    localparam logic [3:0] CTR_SRA  = 4'b1100;
    localparam logic [3:0] CTR_NOR  = 4'b1101;
    localparam logic [3:0] CTR_XOR  = 4'b1110;
    localparam logic [3:0] CTR_LUI  = 4'b1111;

    // ALUOp classes from main control
    localparam logic [2:0] OP_MEM   = 3'b000;
    localparam logic [2:0] OP_BR    = 3'b001;
    localparam logic [2:0] OP_ITYPE = 3'b010;
    localparam logic [2:0] OP_ORI   = 3'b011;
    localparam logic [2:0] OP_RTYPE = 3'b100;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // I-type opcodes
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    // R-type funct -> {illegal, ALUCtr}. jr is legal and runs ADD even
    // though the datapath discards the result.
    function automatic logic [4:0] rtype_decode(input logic [5:0] funct);
        logic [4:0] result;
        result = {1'b1, CTR_ADD};
        case (funct)
            FN_ADD:          result = {1'b0, CTR_ADD};
            FN_ADDU:         result = {1'b0, CTR_ADDU};
            FN_SUB:          result = {1'b0, CTR_SUB};
            FN_SUBU:         result = {1'b0, CTR_SUBU};
            FN_AND:          result = {1'b0, CTR_AND};
            FN_OR:           result = {1'b0, CTR_OR};
            FN_XOR:          result = {1'b0, CTR_XOR};
            FN_NOR:          result = {1'b0, CTR_NOR};
            FN_SLT:          result = {1'b0, CTR_SLT};
            FN_SLTU:         result = {1'b0, CTR_SLTU};
            FN_SLL, FN_SLLV: result = {1'b0, CTR_SLL};
            FN_SRL, FN_SRLV: result = {1'b0, CTR_SRL};
            FN_SRA, FN_SRAV: result = {1'b0, CTR_SRA};
            FN_JR:           result = {1'b0, CTR_ADD};
            default:         result = {1'b1, CTR_ADD};
        endcase
        return result;
    endfunction

    // I-type opcode -> {illegal, ALUCtr}
    function automatic logic [4:0] itype_decode(input logic [5:0] opcode);
        logic [4:0] result;
        result = {1'b1, CTR_ADD};
        case (opcode)
            OPC_ADDI:  result = {1'b0, CTR_ADD};
            OPC_ADDIU: result = {1'b0, CTR_ADDU};
            OPC_SLTI:  result = {1'b0, CTR_SLT};
            OPC_SLTIU: result = {1'b0, CTR_SLTU};
            OPC_ANDI:  result = {1'b0, CTR_AND};
            OPC_ORI:   result = {1'b0, CTR_OR};
            OPC_XORI:  result = {1'b0, CTR_XOR};
            OPC_LUI:   result = {1'b0, CTR_LUI};
            default:   result = {1'b1, CTR_ADD};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/alu_32_control.sv
// ---------------------------------------------------------------------------
// alu_32_control
// ALU control decoder for the MIPS single-cycle datapath.
// Ports:
//   clk          in   clock, drives only the sticky status register
//   rst          in   synchronous active-high reset
//   ALUOp[2:0]   in   ALU operation class from main control
//   func[5:0]    in   funct (ALUOp=100) or opcode (ALUOp=010)
//   ALUCtr[3:0]  out  ALU operation select, combinational
//   illegal      out  combinational flag for an unsupported ALUOp/func pair
//   illegal_seen out  registered sticky record of any illegal decode
// ---------------------------------------------------------------------------
module alu_32_control
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ALUOp,
    input  logic [5:0] func,
    output logic [3:0] ALUCtr,
    output logic       illegal,
    output logic       illegal_seen
);

    logic [4:0] w_decode;
    logic       r_illegalSeen;

    // Select the decode for the current ALUOp class. The default arm covers
    // the unused classes (and X/Z on ALUOp), so every path assigns w_decode
    // and nothing can latch.
    always_comb begin
        w_decode = {1'b1, CTR_ADD};
        case (ALUOp)
            OP_MEM:   w_decode = {1'b0, CTR_ADD};
            OP_BR:    w_decode = {1'b0, CTR_SUB};
            OP_ITYPE: w_decode = itype_decode(func);
            OP_ORI:   w_decode = {1'b0, CTR_OR};
            OP_RTYPE: w_decode = rtype_decode(func);
            default:  w_decode = {1'b1, CTR_ADD};
        endcase
    end

    assign ALUCtr  = w_decode[3:0];
    assign illegal = w_decode[4];

    // Sticky status: reset has priority over a coincident illegal decode,
    // otherwise any illegal decode at a clock edge sets the flag for good.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegalSeen <= 1'b0;
        end else if (illegal) begin
            r_illegalSeen <= 1'b1;
        end
    end

    assign illegal_seen = r_illegalSeen;

endmodule

// File: tb/tb_alu_32_control.sv
// ---------------------------------------------------------------------------
// tb_alu_32_control
// Directed and random checks of the ALU control decoder against a
// table-driven reference model and a sticky-flag model.
// ---------------------------------------------------------------------------
module tb_alu_32_control;

    logic       clk;
    logic       rst;
    logic [2:0] ALUOp;
    logic [5:0] func;
    logic [3:0] ALUCtr;
    logic       illegal;
    logic       illegal_seen;

    int assertions = 0;
    int failures   = 0;
    logic modelSeen = 1'b0;

    // Reference tables: each entry is {code[5:0], ALUCtr[3:0]}
    logic [9:0] rTable [17] = '{
        {6'b100000, 4'b0010}, {6'b100001, 4'b0011}, {6'b100010, 4'b0110},
        {6'b100011, 4'b0111}, {6'b100100, 4'b0000}, {6'b100101, 4'b0001},
        {6'b100110, 4'b1110}, {6'b100111, 4'b1101}, {6'b101010, 4'b1000},
        {6'b101011, 4'b1001}, {6'b000000, 4'b1010}, {6'b000100, 4'b1010},
        {6'b000010, 4'b1011}, {6'b000110, 4'b1011}, {6'b000011, 4'b1100},
        {6'b000111, 4'b1100}, {6'b001000, 4'b0010}
    };
    logic [9:0] iTable [8] = '{
        {6'b001000, 4'b0010}, {6'b001001, 4'b0011}, {6'b001010, 4'b1000},
        {6'b001011, 4'b1001}, {6'b001100, 4'b0000}, {6'b001101, 4'b0001},
        {6'b001110, 4'b1110}, {6'b001111, 4'b1111}
    };

    alu_32_control dut (
        .clk          (clk),
        .rst          (rst),
        .ALUOp        (ALUOp),
        .func         (func),
        .ALUCtr       (ALUCtr),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: returns {illegal, ALUCtr} by table lookup
    function automatic logic [4:0] refDecode(input logic [2:0] op, input logic [5:0] fn);
        logic [4:0] res;
        res = {1'b1, 4'b0010};
        if (op == 3'd0) res = {1'b0, 4'b0010};
        else if (op == 3'd1) res = {1'b0, 4'b0110};
        else if (op == 3'd3) res = {1'b0, 4'b0001};
        else if (op == 3'd2) begin
            for (int k = 0; k < 8; k++)
                if (iTable[k][9:4] == fn) res = {1'b0, iTable[k][3:0]};
        end else if (op == 3'd4) begin
            for (int k = 0; k < 17; k++)
                if (rTable[k][9:4] == fn) res = {1'b0, rTable[k][3:0]};
        end
        return res;
    endfunction

    // Drive decoder inputs and let combinational logic settle
    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn);
        ALUOp = op;
        func  = fn;
        #1;
    endtask

    // Compare combinational outputs against given expectations
    task automatic checkOutput(input string tag, input logic [3:0] expCtr, input logic expIll);
        assertions++;
        assert (ALUCtr === expCtr) else begin
            failures++;
            $error("[TB] FAIL %s ALUCtr: observed %b expected %b", tag, ALUCtr, expCtr);
        end
        assertions++;
        assert (illegal === expIll) else begin
            failures++;
            $error("[TB] FAIL %s illegal: observed %b expected %b", tag, illegal, expIll);
        end
    endtask

    // Compare combinational outputs against the reference model
    task automatic checkModel(input string tag);
        logic [4:0] exp;
        exp = refDecode(ALUOp, func);
        checkOutput(tag, exp[3:0], exp[4]);
    endtask

    // Clock one edge, advance the sticky model, then check illegal_seen
    task automatic stepClock(input string tag);
        logic [4:0] exp;
        exp = refDecode(ALUOp, func);
        if (rst) modelSeen = 1'b0;
        else if (exp[4]) modelSeen = 1'b1;
        @(posedge clk);
        #1;
        assertions++;
        assert (illegal_seen === modelSeen) else begin
            failures++;
            $error("[TB] FAIL %s illegal_seen: observed %b expected %b", tag, illegal_seen, modelSeen);
        end
    endtask

    logic [5:0] rCodes [9] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                               6'b100100, 6'b100101, 6'b101010, 6'b101011, 6'b000000};
    logic [3:0] rExp   [9] = '{4'b0010, 4'b0011, 4'b0110, 4'b0111,
                               4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010};

    initial begin
        rst = 1'b1;
        applyStimulus(3'b000, 6'b000000);
        stepClock("reset");
        rst = 1'b0;

        // R-type sweep
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3'b100, rCodes[i]);
            checkOutput("rtype", rExp[i], 1'b0);
        end

        // I-type selection
        applyStimulus(3'b010, 6'b001000); checkOutput("addi", 4'b0010, 1'b0);
        applyStimulus(3'b010, 6'b001101); checkOutput("ori", 4'b0001, 1'b0);
        applyStimulus(3'b010, 6'b001111); checkOutput("lui", 4'b1111, 1'b0);
        applyStimulus(3'b010, 6'b001011); checkOutput("sltiu", 4'b1001, 1'b0);

        // Memory and branch classes ignore func
        applyStimulus(3'b000, 6'b100011); checkOutput("lw", 4'b0010, 1'b0);
        applyStimulus(3'b000, 6'b101011); checkOutput("sw", 4'b0010, 1'b0);
        applyStimulus(3'b001, 6'b000100); checkOutput("beq", 4'b0110, 1'b0);
        applyStimulus(3'b001, 6'b000101); checkOutput("bne", 4'b0110, 1'b0);
        applyStimulus(3'b001, 6'b000111); checkOutput("bgtz", 4'b0110, 1'b0);
        applyStimulus(3'b011, 6'b111111); checkOutput("oriclass", 4'b0001, 1'b0);
        stepClock("legal_hold");

        // Illegal decode sets the sticky flag which then holds
        applyStimulus(3'b100, 6'b111111); checkOutput("illegal_rtype", 4'b0010, 1'b1);
        stepClock("sticky_set");
        applyStimulus(3'b100, 6'b100000); checkOutput("back_legal", 4'b0010, 1'b0);
        stepClock("sticky_hold1");
        stepClock("sticky_hold2");

        // Reset wins over a simultaneous illegal input
        rst = 1'b1;
        applyStimulus(3'b111, 6'b000000); checkOutput("illegal_in_reset", 4'b0010, 1'b1);
        stepClock("reset_wins");
        rst = 1'b0;
        stepClock("set_after_reset");

        // Combinational update without any clock edge
        applyStimulus(3'b100, 6'b100100); checkOutput("comb_a", 4'b0000, 1'b0);
        applyStimulus(3'b100, 6'b100111); checkOutput("comb_b", 4'b1101, 1'b0);
        applyStimulus(3'b100, 6'b000011); checkOutput("comb_c", 4'b1100, 1'b0);

        // Random stimulus, biased towards listed codes
        for (int n = 0; n < 300; n++) begin
            logic [5:0] fn;
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: fn = rTable[$urandom_range(0, 16)][9:4];
                1: fn = iTable[$urandom_range(0, 7)][9:4];
                default: fn = 6'($urandom);
            endcase
            rst = ($urandom_range(0, 9) == 0);
            applyStimulus(op, fn);
            checkModel("random");
            stepClock("random_sticky");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
